adt7420_temp_filter: RTL and testbench

//   Downstream conditioning stage for ADT7420 I2C read results. Consumes each completed

---
 rtl/adt7420_temp_filter.sv | 221 ++++++++++++++++++++++
 tb/tb_adt7420_temp_filter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_temp_filter.sv
// -----------------------------------------------------------------------------
// adt7420_temp_filter
//
// Conditioning stage for completed ADT7420 temperature reads. Each accepted
// DATAH/DATAL pair is decoded to a 13-bit signed temperature (1/16 degC/LSB).
// The block keeps a 2^AVG_LOG2-deep moving average, min/max statistics and an
// over-temperature alarm with hysteresis.
//
// Handshake: sample_valid is a one-cycle pulse with no ready. It is accepted
// only when the FSM is IDLE (busy=0) and clear=0. A pulse seen while busy is
// dropped and sets the sticky overrun flag. result_strobe pulses for one
// cycle, in the cycle the result outputs first show their new values, three
// edges after the accepting edge.
//
// Ports
//   FSM_Clk        in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   sample_valid   in   new DATAH/DATAL pair present (1-cycle pulse)
//   DATAH, DATAL   in   ADT7420 temperature bytes (DATAL[2:0] are flags)
//   clear          in   synchronous clear of all statistics, aborts work
//   busy           out  FSM is not IDLE
//   result_strobe  out  result outputs updated this cycle
//   temp_raw       out  latest decoded sample (signed 13b)
//   temp_avg       out  moving average (signed, sign-extended to 16b)
//   temp_min/max   out  extremes since reset/clear (signed 13b)
//   avg_valid      out  averaging window is completely filled
//   alarm          out  hysteresis over-temperature flag
//   overrun        out  sticky: sample arrived while busy
//   sample_count   out  accepted samples, saturating
//   fsm_state      out  current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module adt7420_temp_filter #(
   parameter int                 AVG_LOG2 = 3,
   parameter logic signed [12:0] ALARM_HI = 13'sd480,
   parameter logic signed [12:0] ALARM_LO = 13'sd448
) (
   input  logic        FSM_Clk,
   input  logic        rst_n,
   input  logic        sample_valid,
   input  logic [7:0]  DATAH,
   input  logic [7:0]  DATAL,
   input  logic        clear,
   output logic        busy,
   output logic        result_strobe,
   output logic [12:0] temp_raw,
   output logic [15:0] temp_avg,
   output logic [12:0] temp_min,
   output logic [12:0] temp_max,
   output logic        avg_valid,
   output logic        alarm,
   output logic        overrun,
   output logic [15:0] sample_count,
   output logic [1:0]  fsm_state
);

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int AW    = 13 + AVG_LOG2;
   localparam logic [AVG_LOG2:0] FULL = (AVG_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_UPDATE  = 2'd2,
      S_PUBLISH = 2'd3
   } state_t;

   state_t               state_q;
   logic signed [12:0]   raw_q;
   logic signed [12:0]   old_q;
   logic signed [12:0]   buf_q [DEPTH];
   logic signed [AW-1:0] acc_q;
   logic [AVG_LOG2-1:0]  wr_ptr_q;
   logic [AVG_LOG2:0]    fill_q;

   logic                 strobe_q;
   logic signed [12:0]   temp_raw_q;
   logic signed [15:0]   temp_avg_q;
   logic signed [12:0]   temp_min_q;
   logic signed [12:0]   temp_max_q;
   logic                 avg_valid_q;
   logic                 alarm_q;
   logic                 overrun_q;
   logic [15:0]          count_q;

   logic signed [12:0]   raw_d;
   logic signed [AW-1:0] acc_d;
   logic signed [12:0]   avg_d;
   logic                 avg_valid_d;
   logic                 alarm_d;
   logic signed [12:0]   min_d;
   logic signed [12:0]   max_d;
   logic [15:0]          count_d;
   logic                 unused_flags;

   // The low three DATAL bits are ADT7420 status flags, not temperature.
   assign unused_flags = ^DATAL[2:0];

   always_comb begin
      raw_d = $signed({DATAH, DATAL[7:3]});
      // Running sum: drop the sample leaving the window, add the new one.
      acc_d = acc_q
            - $signed({{AVG_LOG2{old_q[12]}}, old_q})
            + $signed({{AVG_LOG2{raw_q[12]}}, raw_q});
      // Upper 13 bits of the sum are exactly acc >>> AVG_LOG2 (floor); the
      // average of 13-bit values always fits back into 13 bits.
      avg_d       = acc_q[AW-1:AVG_LOG2];
      avg_valid_d = (fill_q == FULL);
      alarm_d     = 1'b0;
      if (avg_valid_d) begin
         if (avg_d >= ALARM_HI) begin
            alarm_d = 1'b1;
         end else if (avg_d < ALARM_LO) begin
            alarm_d = 1'b0;
         end else begin
            alarm_d = alarm_q;
         end
      end
      // A zero count means no sample has been published since reset/clear,
      // so the first one seeds both extremes.
      min_d   = ((count_q == 16'd0) || (raw_q < temp_min_q)) ? raw_q : temp_min_q;
      max_d   = ((count_q == 16'd0) || (raw_q > temp_max_q)) ? raw_q : temp_max_q;
      count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
   end

   always_ff @(posedge FSM_Clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         raw_q       <= '0;
         old_q       <= '0;
         acc_q       <= '0;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         strobe_q    <= 1'b0;
         temp_raw_q  <= '0;
         temp_avg_q  <= '0;
         temp_min_q  <= '0;
         temp_max_q  <= '0;
         avg_valid_q <= 1'b0;
         alarm_q     <= 1'b0;
         overrun_q   <= 1'b0;
         count_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else if (clear) begin
         // Clear wins over everything: in-flight work is abandoned and a
         // coincident sample_valid is ignored without flagging overrun.
         state_q     <= S_IDLE;
         raw_q       <= '0;
         old_q       <= '0;
         acc_q       <= '0;
         wr_ptr_q    <= '0;
         fill_q      <= '0;
         strobe_q    <= 1'b0;
         temp_raw_q  <= '0;
         temp_avg_q  <= '0;
         temp_min_q  <= '0;
         temp_max_q  <= '0;
         avg_valid_q <= 1'b0;
         alarm_q     <= 1'b0;
         overrun_q   <= 1'b0;
         count_q     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            buf_q[i] <= '0;
         end
      end else begin
         strobe_q <= 1'b0;
         if (sample_valid && (state_q != S_IDLE)) begin
            overrun_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (sample_valid) begin
                  raw_q   <= raw_d;
                  state_q <= S_CAPTURE;
               end
            end
            S_CAPTURE: begin
               old_q   <= buf_q[wr_ptr_q];
               state_q <= S_UPDATE;
            end
            S_UPDATE: begin
               acc_q           <= acc_d;
               buf_q[wr_ptr_q] <= raw_q;
               wr_ptr_q        <= wr_ptr_q + 1'b1;
               if (fill_q != FULL) begin
                  fill_q <= fill_q + 1'b1;
               end
               state_q <= S_PUBLISH;
            end
            S_PUBLISH: begin
               temp_raw_q  <= raw_q;
               temp_avg_q  <= {{3{avg_d[12]}}, avg_d};
               temp_min_q  <= min_d;
               temp_max_q  <= max_d;
               count_q     <= count_d;
               avg_valid_q <= avg_valid_d;
               alarm_q     <= alarm_d;
               strobe_q    <= 1'b1;
               state_q     <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy          = (state_q != S_IDLE);
   assign result_strobe = strobe_q;
   assign temp_raw      = temp_raw_q;
   assign temp_avg      = temp_avg_q;
   assign temp_min      = temp_min_q;
   assign temp_max      = temp_max_q;
   assign avg_valid     = avg_valid_q;
   assign alarm         = alarm_q;
   assign overrun       = overrun_q;
   assign sample_count  = count_q;
   assign fsm_state     = state_q;

endmodule

// File: tb/tb_adt7420_temp_filter.sv
// -----------------------------------------------------------------------------
// tb_adt7420_temp_filter
//
// Bench for adt7420_temp_filter (default parameters: 8-sample window,
// alarm 480/448). A behavioural model keeps the accepted samples in a queue
// and derives every output from plain arithmetic; a negedge process compares
// all outputs to it every cycle. Directed sequences pin the model with
// hand-computed literals, then a randomized phase mixes samples, overruns and
// clears.
// -----------------------------------------------------------------------------
module tb_adt7420_temp_filter;

   localparam int WIN = 8;

   // ---------------------------------------------------------------- clock/reset
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [7:0]  datah = 8'h00;
   logic [7:0]  datal = 8'h00;
   logic        clear = 1'b0;
   logic        busy;
   logic        result_strobe;
   logic [12:0] temp_raw;
   logic [15:0] temp_avg;
   logic [12:0] temp_min;
   logic [12:0] temp_max;
   logic        avg_valid;
   logic        alarm;
   logic        overrun;
   logic [15:0] sample_count;
   logic [1:0]  fsm_state;

   always #5 clk = ~clk;

   adt7420_temp_filter dut (
      .FSM_Clk       (clk),
      .rst_n         (rst_n),
      .sample_valid  (sample_valid),
      .DATAH         (datah),
      .DATAL         (datal),
      .clear         (clear),
      .busy          (busy),
      .result_strobe (result_strobe),
      .temp_raw      (temp_raw),
      .temp_avg      (temp_avg),
      .temp_min      (temp_min),
      .temp_max      (temp_max),
      .avg_valid     (avg_valid),
      .alarm         (alarm),
      .overrun       (overrun),
      .sample_count  (sample_count),
      .fsm_state     (fsm_state)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   int  exp_q[$];          // accepted samples inside the averaging window
   int  cyc = 0;
   bit  m_pending = 0;
   int  m_due = 0;
   int  m_val = 0;
   bit  m_strobe = 0;
   int  m_raw = 0, m_avg = 0, m_min = 0, m_max = 0, m_count = 0;
   bit  m_avg_valid = 0, m_alarm = 0, m_overrun = 0;
   bit  m_was_busy;

   function automatic int decode(input logic [7:0] h, input logic [7:0] l);
      int v;
      v = int'(h) * 32 + int'(l) / 8;
      if (v >= 4096) v -= 8192;
      return v;
   endfunction

   function automatic int floor_div(input int s, input int d);
      int q;
      q = s / d;
      if ((s % d) != 0 && s < 0) q = q - 1;
      return q;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_pending = 0; m_strobe = 0;
      m_raw = 0; m_avg = 0; m_min = 0; m_max = 0; m_count = 0;
      m_avg_valid = 0; m_alarm = 0; m_overrun = 0;
   endtask

   task automatic model_publish(input int v);
      int sum;
      exp_q.push_back(v);
      if (exp_q.size() > WIN) void'(exp_q.pop_front());
      sum = 0;
      foreach (exp_q[i]) sum += exp_q[i];
      m_avg = floor_div(sum, WIN);
      m_raw = v;
      if (m_count == 0) begin
         m_min = v; m_max = v;
      end else begin
         if (v < m_min) m_min = v;
         if (v > m_max) m_max = v;
      end
      if (m_count < 65535) m_count++;
      m_avg_valid = (exp_q.size() == WIN);
      if (!m_avg_valid) m_alarm = 0;
      else if (m_avg >= 480) m_alarm = 1;
      else if (m_avg < 448) m_alarm = 0;
      m_strobe = 1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         cyc++;
         if (clear) begin
            model_reset();
         end else begin
            m_was_busy = m_pending;
            m_strobe = 0;
            if (m_pending && cyc == m_due) begin
               model_publish(m_val);
               m_pending = 0;
            end
            if (sample_valid) begin
               if (m_was_busy) begin
                  m_overrun = 1;
               end else begin
                  m_pending = 1;
                  m_due = cyc + 3;
                  m_val = decode(datah, datal);
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------- scoreboard
   always @(negedge clk) begin
      logic [12:0] e_raw, e_min, e_max;
      logic [15:0] e_avg;
      e_raw = m_raw[12:0];
      e_min = m_min[12:0];
      e_max = m_max[12:0];
      e_avg = m_avg[15:0];
      check("busy",          {31'b0, busy},          {31'b0, m_pending});
      check("result_strobe", {31'b0, result_strobe}, {31'b0, m_strobe});
      check("temp_raw",      {19'b0, temp_raw},      {19'b0, e_raw});
      check("temp_avg",      {16'b0, temp_avg},      {16'b0, e_avg});
      check("temp_min",      {19'b0, temp_min},      {19'b0, e_min});
      check("temp_max",      {19'b0, temp_max},      {19'b0, e_max});
      check("avg_valid",     {31'b0, avg_valid},     {31'b0, m_avg_valid});
      check("alarm",         {31'b0, alarm},         {31'b0, m_alarm});
      check("overrun",       {31'b0, overrun},       {31'b0, m_overrun});
      check("sample_count",  {16'b0, sample_count},  {16'b0, m_count[15:0]});
   end

   // ---------------------------------------------------------------- drivers
   task automatic send(input logic [7:0] h, input logic [7:0] l);
      @(posedge clk); #1;
      sample_valid = 1'b1; datah = h; datal = l;
      @(posedge clk); #1;
      sample_valid = 1'b0;
   endtask

   // Returns the number of negedges waited; a strobe 3 edges after the
   // accepting edge shows up at index 3.
   task automatic wait_strobe(output int lat, output bit seen);
      seen = 0; lat = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (result_strobe) begin
            seen = 1; lat = k;
            break;
         end
      end
   endtask

   task automatic pulse_clear();
      @(posedge clk); #1; clear = 1'b1;
      @(posedge clk); #1; clear = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #3; rst_n = 1'b0;
      @(posedge clk); #3; rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) @(posedge clk);
   endtask

   // ---------------------------------------------------------------- stimulus
   initial begin
      int  lat;
      bit  seen;
      int  n440;
      logic [15:0] cnt_before;

      #23 rst_n = 1'b1;
      @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_count", {16'b0, sample_count}, 32'd0);

      // Eight samples of 25.0 degC.
      for (int i = 0; i < 8; i++) begin
         send(8'h0C, 8'h80);
         wait_strobe(lat, seen);
         check("t2_strobe_seen", {31'b0, seen}, 32'd1);
         check("t2_latency", lat, 32'd3);
      end
      check("t2_avg_valid", {31'b0, avg_valid}, 32'd1);
      check("t2_avg", {16'b0, temp_avg}, 32'd400);
      check("t2_min", {19'b0, temp_min}, 32'd400);
      check("t2_max", {19'b0, temp_max}, 32'd400);
      check("t2_count", {16'b0, sample_count}, 32'd8);

      // Asynchronous reset in the middle of a transaction.
      send(8'h0C, 8'h80);
      @(posedge clk); #3; rst_n = 1'b0;
      #1;
      check("t1_async_zero",
            {31'b0, |{busy, result_strobe, temp_raw, temp_avg, temp_min, temp_max,
                      avg_valid, alarm, overrun, sample_count}}, 32'd0);
      @(posedge clk); #3; rst_n = 1'b1;
      @(negedge clk);
      check("t1_idle_after", {31'b0, busy}, 32'd0);

      // Negative temperature, flag bits set.
      send(8'hFF, 8'h87);
      wait_strobe(lat, seen);
      check("t3_strobe_seen", {31'b0, seen}, 32'd1);
      check("t3_raw", {19'b0, temp_raw}, 32'h1FF0);
      check("t3_min", {19'b0, temp_min}, 32'h1FF0);
      check("t3_max", {19'b0, temp_max}, 32'h1FF0);
      check("t3_avg", {16'b0, temp_avg}, 32'hFFFE);

      // Alarm set, hold inside the hysteresis band, then clear.
      pulse_clear();
      for (int i = 0; i < 8; i++) begin
         send(8'h0F, 8'h00);
         wait_strobe(lat, seen);
      end
      check("t4_alarm_set", {31'b0, alarm}, 32'd1);
      check("t4_avg480", {16'b0, temp_avg}, 32'd480);
      send(8'h0E, 8'h40);
      wait_strobe(lat, seen);
      check("t4_avg477", {16'b0, temp_avg}, 32'd477);
      check("t4_alarm_hold", {31'b0, alarm}, 32'd1);
      n440 = 0;
      for (int i = 0; i < 12; i++) begin
         send(8'h0D, 8'hC0);
         wait_strobe(lat, seen);
         n440++;
         if (!alarm) break;
      end
      check("t4_alarm_clear", {31'b0, alarm}, 32'd0);
      check("t4_n440", n440, 32'd6);
      check("t4_avg447", {16'b0, temp_avg}, 32'd447);

      // Back-to-back sample_valid: second one is an overrun.
      cnt_before = sample_count;
      @(posedge clk); #1; sample_valid = 1'b1; datah = 8'h10; datal = 8'h00;
      @(posedge clk); #1;
      @(posedge clk); #1; sample_valid = 1'b0;
      wait_strobe(lat, seen);
      check("t5_strobe_seen", {31'b0, seen}, 32'd1);
      wait_strobe(lat, seen);
      check("t5_single_strobe", {31'b0, seen}, 32'd0);
      check("t5_count", {16'b0, sample_count}, {16'b0, cnt_before + 16'd1});
      check("t5_overrun", {31'b0, overrun}, 32'd1);
      idle(5);
      @(negedge clk);
      check("t5_overrun_sticky", {31'b0, overrun}, 32'd1);
      pulse_clear();
      @(negedge clk);
      check("t5_overrun_cleared", {31'b0, overrun}, 32'd0);

      // Clear one cycle after a sample: no result, stats zero.
      send(8'h0C, 8'h80);
      pulse_clear();
      @(negedge clk);
      check("t6_busy", {31'b0, busy}, 32'd0);
      check("t6_count", {16'b0, sample_count}, 32'd0);
      check("t6_avg_valid", {31'b0, avg_valid}, 32'd0);
      wait_strobe(lat, seen);
      check("t6_no_strobe", {31'b0, seen}, 32'd0);

      // Randomized traffic: dense enough to provoke overruns, with
      // occasional clears (sometimes coincident with a sample).
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #1;
         sample_valid = ($urandom_range(0, 3) == 0);
         clear        = ($urandom_range(0, 60) == 0);
         datah        = 8'($urandom_range(0, 255));
         datal        = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      sample_valid = 1'b0;
      clear = 1'b0;
      idle(6);
      @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
